// File: rtl/camera_pkg.sv
// rtl/camera_pkg.sv - shared frame geometry, pixel field positions and capture state encoding
package camera_pkg;

    localparam int SCREEN_WIDTH  = 176;
    localparam int SCREEN_HEIGHT = 144;
    localparam int ADDR_W        = 15;

    // MSB of each colour field inside an RGB444 word {R,G,B}
    localparam int R444_MSB = 11;
    localparam int G444_MSB = 7;
    localparam int B444_MSB = 3;

    typedef logic [11:0] rgb444_t;
    typedef logic [7:0]  rgb332_t;

    typedef enum logic [1:0] {
        WAIT_VS  = 2'd0,
        IN_VS    = 2'd1,
        WAIT_ROW = 2'd2,
        ROW      = 2'd3
    } cap_state_t;

endpackage

// File: rtl/camera_capture_if.sv
// rtl/camera_capture_if.sv - camera byte stream in, frame-buffer write port out
interface camera_capture_if #(
    parameter int AW = camera_pkg::ADDR_W
);
    logic          vsync;
    logic          href;
    logic [7:0]    data;
    logic          w_en;
    logic [AW-1:0] write_address;
    logic [7:0]    pixel_data;
    logic          frame_done;
    logic          row_err;

    modport master (
        output vsync, href, data,
        input  w_en, write_address, pixel_data, frame_done, row_err
    );

    modport slave (
        input  vsync, href, data,
        output w_en, write_address, pixel_data, frame_done, row_err
    );
endinterface

// File: rtl/rgb444_to_rgb332.sv
// rtl/rgb444_to_rgb332.sv - truncating colour-depth reduction, keeps the top bits of each field
module rgb444_to_rgb332
    import camera_pkg::*;
(
    input  rgb444_t rgb444,
    output rgb332_t rgb332
);
    logic unused_lsbs;

    assign rgb332      = {rgb444[R444_MSB -: 3], rgb444[G444_MSB -: 3], rgb444[B444_MSB -: 2]};
    assign unused_lsbs = ^{rgb444[8], rgb444[4], rgb444[1:0]};
endmodule

// File: rtl/camera_capture.sv
// rtl/camera_capture.sv - pairs camera bytes into pixels and writes RGB332 into the frame buffer
module camera_capture
    import camera_pkg::*;
#(
    parameter int WIDTH  = SCREEN_WIDTH,
    parameter int HEIGHT = SCREEN_HEIGHT,
    parameter int ADDR_W = camera_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    camera_capture_if.slave   bus
);
    localparam int XW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(HEIGHT + 1);
    localparam logic [XW-1:0]     X_MAX    = XW'(WIDTH);
    localparam logic [XW-1:0]     X_LAST   = XW'(WIDTH - 1);
    localparam logic [YW-1:0]     Y_MAX    = YW'(HEIGHT);
    localparam logic [YW-1:0]     Y_LAST   = YW'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH);

    logic              vs_q;
    logic              href_q;
    logic [7:0]        data_q;

    cap_state_t        state;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] row_base;
    logic              phase;
    logic [3:0]        r_nib;
    logic              row_err;

    logic              sched;
    logic [ADDR_W-1:0] sched_addr;
    rgb332_t           sched_pix;
    logic              sched_last;
    rgb332_t           pix332;

    logic              w_en;
    logic [ADDR_W-1:0] write_address;
    rgb332_t           pixel_data;
    logic              frame_done;

    rgb444_to_rgb332 u_conv (
        .rgb444 ({r_nib, data_q}),
        .rgb332 (pix332)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q   <= 1'b0;
            href_q <= 1'b0;
            data_q <= 8'h00;
        end else begin
            vs_q   <= bus.vsync;
            href_q <= bus.href;
            data_q <= bus.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WAIT_VS;
            x          <= '0;
            y          <= '0;
            row_base   <= '0;
            phase      <= 1'b0;
            r_nib      <= 4'h0;
            row_err    <= 1'b0;
            sched      <= 1'b0;
            sched_addr <= '0;
            sched_pix  <= '0;
            sched_last <= 1'b0;
        end else begin
            sched <= 1'b0;
            // VSYNC overrides every state, including a row ending in the same cycle
            if (vs_q) begin
                state    <= IN_VS;
                x        <= '0;
                y        <= '0;
                row_base <= '0;
                phase    <= 1'b0;
                row_err  <= 1'b0;
            end else begin
                unique case (state)
                    WAIT_VS: state <= WAIT_VS;
                    IN_VS:   state <= WAIT_ROW;
                    WAIT_ROW: begin
                        if (href_q) begin
                            r_nib <= data_q[3:0];
                            phase <= 1'b1;
                            state <= ROW;
                        end
                    end
                    ROW: begin
                        if (href_q) begin
                            if (!phase) begin
                                r_nib <= data_q[3:0];
                                phase <= 1'b1;
                            end else begin
                                phase <= 1'b0;
                                if (x == X_MAX) begin
                                    row_err <= 1'b1;
                                end else begin
                                    x <= x + 1'b1;
                                    if (y != Y_MAX) begin
                                        sched      <= 1'b1;
                                        sched_addr <= row_base + ADDR_W'(x);
                                        sched_pix  <= pix332;
                                        sched_last <= (x == X_LAST) && (y == Y_LAST);
                                    end
                                end
                            end
                        end else begin
                            if (phase)
                                row_err <= 1'b1;
                            phase <= 1'b0;
                            x     <= '0;
                            // x != 0 means this row produced at least one pixel
                            if (x != '0 && y != Y_MAX) begin
                                y        <= y + 1'b1;
                                row_base <= row_base + ROW_STEP;
                            end
                            state <= WAIT_ROW;
                        end
                    end
                    default: state <= WAIT_VS;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_en          <= 1'b0;
            write_address <= '0;
            pixel_data    <= '0;
            frame_done    <= 1'b0;
        end else begin
            w_en       <= sched;
            frame_done <= sched & sched_last;
            if (sched) begin
                write_address <= sched_addr;
                pixel_data    <= sched_pix;
            end
        end
    end

    assign bus.w_en          = w_en;
    assign bus.write_address = write_address;
    assign bus.pixel_data    = pixel_data;
    assign bus.frame_done    = frame_done;
    assign bus.row_err       = row_err;

endmodule

// File: tb/tb_camera_capture.sv
// tb/tb_camera_capture.sv - randomized stimulus against a per-row frame model
module tb_camera_capture;
    localparam int W = 176;
    localparam int H = 144;

    typedef struct packed {
        logic [14:0] addr;
        logic [7:0]  data;
        logic        fd;
    } wr_t;

    logic clk;
    logic rst;
    camera_capture_if bif ();

    camera_capture dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int fd_cnt = 0;

    wr_t        act_q[$];
    wr_t        exp_q[$];
    logic [7:0] byte_q[$];

    bit   armed = 0;
    int   my    = 0;
    logic merr  = 1'b0;

    always @(negedge clk) begin
        if (bif.w_en === 1'b1)
            act_q.push_back('{addr: bif.write_address, data: bif.pixel_data, fd: bif.frame_done});
        if (bif.frame_done === 1'b1)
            fd_cnt++;
    end

    function automatic logic [7:0] to332(input logic [7:0] b0, input logic [7:0] b1);
        logic [3:0] r = b0[3:0];
        logic [3:0] g = b1[7:4];
        logic [3:0] b = b1[3:0];
        return {r[3:1], g[3:1], b[3:2]};
    endfunction

    // One row of the model: pixel i of row y lands at y*W+i unless clipped
    function automatic void model_row();
        int npix = byte_q.size() / 2;
        if (!armed) return;
        for (int i = 0; i < npix; i++)
            if (i < W && my < H)
                exp_q.push_back('{addr: 15'(my * W + i), data: to332(byte_q[2*i], byte_q[2*i+1]),
                                  fd: (i == W-1 && my == H-1)});
        if ((byte_q.size() % 2) != 0 || npix > W) merr = 1'b1;
        if (npix > 0) my++;
    endfunction

    function automatic int first_diff();
        int n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (act_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    function automatic int exp_fd();
        int c = 0;
        foreach (exp_q[i]) if (exp_q[i].fd) c++;
        return c;
    endfunction

    task automatic start_test();
        act_q.delete();
        exp_q.delete();
        fd_cnt = 0;
    endtask

    task automatic send_vsync();
        @(negedge clk) bif.vsync = 1'b1;
        repeat (3) @(negedge clk);
        bif.vsync = 1'b0;
        repeat (3) @(negedge clk);
        armed = 1;
        my    = 0;
        merr  = 1'b0;
    endtask

    task automatic send_row(input int gap);
        foreach (byte_q[i]) begin
            @(negedge clk);
            bif.href = 1'b1;
            bif.data = byte_q[i];
        end
        @(negedge clk);
        bif.href = 1'b0;
        bif.data = 8'($urandom);
        repeat (gap - 1) @(negedge clk);
        model_row();
    endtask

    task automatic fill_fixed(input int npix, input logic [7:0] b0, input logic [7:0] b1);
        byte_q.delete();
        for (int i = 0; i < npix; i++) begin
            byte_q.push_back(b0);
            byte_q.push_back(b1);
        end
    endtask

    task automatic fill_random(input int nbytes);
        byte_q.delete();
        for (int i = 0; i < nbytes; i++) byte_q.push_back(8'($urandom));
    endtask

    task automatic flush();
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        int d;
        bif.vsync = 1'b0;
        bif.href  = 1'b0;
        bif.data  = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (bif.w_en !== 1'b0) begin n_fail++; $display("FAIL reset_w_en: got %b want 0", bif.w_en); end
        n_chk++; if (bif.write_address !== 15'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", bif.write_address); end
        n_chk++; if (bif.pixel_data !== 8'h00) begin n_fail++; $display("FAIL reset_pixel: got %h want 00", bif.pixel_data); end
        n_chk++; if (bif.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", bif.frame_done); end
        n_chk++; if (bif.row_err !== 1'b0) begin n_fail++; $display("FAIL reset_row_err: got %b want 0", bif.row_err); end
        rst = 1'b0;
        start_test();
        armed = 0;
        fill_random(40);
        send_row(6);
        flush();
        d = act_q.size();
        n_chk++; if (d != 0) begin n_fail++; $display("FAIL pre_vsync_writes: got %0d want 0", d); end
    endtask

    task automatic test_one_row();
        int d;
        start_test();
        send_vsync();
        fill_fixed(W, 8'h0F, 8'h00);
        send_row(8);
        flush();
        n_chk++; if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL row_count: got %0d want %0d", act_q.size(), exp_q.size()); end
        d = first_diff();
        n_chk++; if (d != -1) begin n_fail++; $display("FAIL row_writes: idx %0d got %h want %h", d, act_q[d], exp_q[d]); end
        n_chk++; if (act_q.size() > 0 && act_q[0].data !== 8'hE0) begin n_fail++; $display("FAIL row_red: got %h want e0", act_q[0].data); end
        n_chk++; if (bif.row_err !== 1'b0) begin n_fail++; $display("FAIL row_err_clean: got %b want 0", bif.row_err); end
    endtask

    task automatic test_full_frame();
        int d;
        start_test();
        send_vsync();
        fill_fixed(W, 8'h00, 8'hF0);
        for (int r = 0; r < H + 2; r++) send_row(8);
        flush();
        n_chk++; if (act_q.size() != W * H) begin n_fail++; $display("FAIL frame_count: got %0d want %0d", act_q.size(), W * H); end
        d = first_diff();
        n_chk++; if (d != -1) begin n_fail++; $display("FAIL frame_writes: idx %0d got %h want %h", d, act_q[d], exp_q[d]); end
        n_chk++; if (act_q.size() > 0 && act_q[$].addr !== 15'd25343) begin n_fail++; $display("FAIL frame_last_addr: got %0d want 25343", act_q[$].addr); end
        n_chk++; if (fd_cnt != 1) begin n_fail++; $display("FAIL frame_done_count: got %0d want 1", fd_cnt); end
        n_chk++; if (bif.row_err !== 1'b0) begin n_fail++; $display("FAIL frame_row_err: got %b want 0", bif.row_err); end
    endtask

    task automatic test_odd_row();
        int d;
        start_test();
        send_vsync();
        byte_q.delete();
        byte_q.push_back(8'h0F); byte_q.push_back(8'hFF); byte_q.push_back(8'h0A);
        send_row(6);
        flush();
        n_chk++; if (bif.row_err !== 1'b1) begin n_fail++; $display("FAIL odd_row_err: got %b want 1", bif.row_err); end
        fill_random(2 * $urandom_range(1, 20));
        send_row(6);
        flush();
        n_chk++; if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL odd_count: got %0d want %0d", act_q.size(), exp_q.size()); end
        d = first_diff();
        n_chk++; if (d != -1) begin n_fail++; $display("FAIL odd_writes: idx %0d got %h want %h", d, act_q[d], exp_q[d]); end
        n_chk++; if (act_q.size() > 1 && act_q[1].addr !== 15'd176) begin n_fail++; $display("FAIL odd_next_row: got %0d want 176", act_q[1].addr); end
    endtask

    task automatic test_long_row();
        int d;
        start_test();
        send_vsync();
        fill_random(2 * (W + 4));
        send_row(6);
        fill_random(2 * 10);
        send_row(6);
        flush();
        n_chk++; if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL long_count: got %0d want %0d", act_q.size(), exp_q.size()); end
        d = first_diff();
        n_chk++; if (d != -1) begin n_fail++; $display("FAIL long_writes: idx %0d got %h want %h", d, act_q[d], exp_q[d]); end
        n_chk++; if (bif.row_err !== merr) begin n_fail++; $display("FAIL long_row_err: got %b want %b", bif.row_err, merr); end
        send_vsync();
        n_chk++; if (bif.row_err !== 1'b0) begin n_fail++; $display("FAIL long_err_cleared: got %b want 0", bif.row_err); end
    endtask

    task automatic test_short_frame();
        int d;
        start_test();
        send_vsync();
        for (int r = 0; r <= 10; r++) begin
            fill_random(2 * W);
            send_row($urandom_range(3, 9));
        end
        send_vsync();
        fill_random(2 * 30);
        send_row(5);
        flush();
        n_chk++; if (fd_cnt != 0) begin n_fail++; $display("FAIL short_frame_done: got %0d want 0", fd_cnt); end
        n_chk++; if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL short_count: got %0d want %0d", act_q.size(), exp_q.size()); end
        d = first_diff();
        n_chk++; if (d != -1) begin n_fail++; $display("FAIL short_writes: idx %0d got %h want %h", d, act_q[d], exp_q[d]); end
    endtask

    task automatic test_reset_mid_row();
        int  d;
        bit  hit = 0;
        start_test();
        send_vsync();
        for (int r = 0; r < 5; r++) begin
            fill_random(2 * W);
            send_row(4);
        end
        flush();
        d = first_diff();
        n_chk++; if (d != -1 || act_q.size() != 5 * W) begin n_fail++; $display("FAIL mid_pre_rows: idx %0d got %0d writes want %0d", d, act_q.size(), 5 * W); end
        // reset lands on a cycle that is actively writing
        for (int i = 0; i < 2 * W && !hit; i++) begin
            @(negedge clk);
            bif.href = 1'b1;
            bif.data = 8'($urandom);
            if (i >= 40 && bif.w_en === 1'b1) begin
                rst = 1'b1;
                hit = 1;
            end
        end
        #1;
        n_chk++; if (!hit || bif.w_en !== 1'b0) begin n_fail++; $display("FAIL mid_reset_w_en: got %b want 0 (reset applied %0d)", bif.w_en, hit); end
        rst = 1'b0;
        armed = 0;
        start_test();
        fill_random(2 * 50);
        send_row(4);
        fill_random(2 * W);
        send_row(4);
        flush();
        n_chk++; if (act_q.size() != 0) begin n_fail++; $display("FAIL mid_unarmed_writes: got %0d want 0", act_q.size()); end
        send_vsync();
        fill_random(2 * W);
        send_row(6);
        flush();
        d = first_diff();
        n_chk++; if (d != -1 || act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL mid_recapture: idx %0d got %0d writes want %0d", d, act_q.size(), exp_q.size()); end
    endtask

    task automatic test_random_rows();
        int d;
        start_test();
        send_vsync();
        for (int r = 0; r < 20; r++) begin
            fill_random($urandom_range(1, 2 * W + 9));
            send_row($urandom_range(3, 10));
        end
        flush();
        n_chk++; if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", act_q.size(), exp_q.size()); end
        d = first_diff();
        n_chk++; if (d != -1) begin n_fail++; $display("FAIL rand_writes: idx %0d got %h want %h", d, act_q[d], exp_q[d]); end
        n_chk++; if (bif.row_err !== merr) begin n_fail++; $display("FAIL rand_row_err: got %b want %b", bif.row_err, merr); end
        n_chk++; if (fd_cnt != exp_fd()) begin n_fail++; $display("FAIL rand_frame_done: got %0d want %0d", fd_cnt, exp_fd()); end
    endtask

    initial begin
        rst       = 1'b1;
        bif.vsync = 1'b0;
        bif.href  = 1'b0;
        bif.data  = 8'h00;
        test_reset();
        test_one_row();
        test_full_frame();
        test_odd_row();
        test_long_row();
        test_short_frame();
        test_reset_mid_row();
        test_random_rows();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
